// File: rtl/iir_biquad_mc.sv
// Multi-channel direct-form-I biquad: shared double-buffered coefficients,
// per-channel history, three compute stages followed by a registered output.
module iir_biquad_mc #(
  parameter  int DW   = 32,
  parameter  int CW   = 18,
  parameter  int FRAC = 14,
  parameter  int NCH  = 4,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CHW-1:0]       in_ch,
  input  logic signed [DW-1:0] x,
  output logic                 out_valid,
  output logic [CHW-1:0]       out_ch,
  output logic signed [DW-1:0] y,
  output logic                 sat_flag,
  input  logic                 bypass,
  input  logic                 coef_we,
  input  logic [2:0]           coef_addr,
  input  logic signed [CW-1:0] coef_data,
  input  logic                 coef_commit,
  output logic                 commit_busy
);

  localparam int PW = DW + CW;
  localparam int AW = DW + CW + 3;
  localparam logic signed [CW-1:0] C_UNITY = CW'(1) << FRAC;
  localparam logic signed [AW-1:0] C_HALF  = AW'(1) << (FRAC - 1);
  localparam logic signed [AW-1:0] C_YMAX  = AW'({1'b0, {(DW-1){1'b1}}});
  localparam logic signed [AW-1:0] C_YMIN  = ~C_YMAX;

  // Coefficient order: 0=b0 1=b1 2=b2 3=a1 4=a2
  logic signed [CW-1:0] r_shadow [5];
  logic signed [CW-1:0] r_active [5];
  logic                 r_commit_busy;
  logic [NCH-1:0]       r_busy;

  logic signed [DW-1:0] r_hx1 [NCH];
  logic signed [DW-1:0] r_hx2 [NCH];
  logic signed [DW-1:0] r_hy1 [NCH];
  logic signed [DW-1:0] r_hy2 [NCH];

  logic                 r_s1_v;
  logic                 r_s1_byp;
  logic [CHW-1:0]       r_s1_ch;
  logic signed [DW-1:0] r_s1_x;
  logic signed [DW-1:0] r_s1_x1;
  logic signed [DW-1:0] r_s1_x2;
  logic signed [DW-1:0] r_s1_y1;
  logic signed [DW-1:0] r_s1_y2;

  logic                 r_s2_v;
  logic                 r_s2_byp;
  logic [CHW-1:0]       r_s2_ch;
  logic signed [DW-1:0] r_s2_x;
  logic signed [PW-1:0] r_s2_p [5];

  logic                 r_s3_v;
  logic                 r_s3_byp;
  logic [CHW-1:0]       r_s3_ch;
  logic signed [DW-1:0] r_s3_x;
  logic signed [AW-1:0] r_s3_acc;

  logic                 w_ch_ok;
  logic                 w_accept;
  logic                 w_drained;
  logic [NCH-1:0]       w_set;
  logic [NCH-1:0]       w_clr;
  logic signed [PW-1:0] w_prod [5];
  logic signed [AW-1:0] w_sum;
  logic signed [AW-1:0] w_rnd;
  logic signed [DW-1:0] w_ysat;
  logic                 w_sat;

  assign w_ch_ok     = int'(in_ch) < NCH;
  assign in_ready    = w_ch_ok && !r_busy[in_ch] && !r_commit_busy;
  assign w_accept    = in_valid && in_ready;
  assign w_drained   = !r_s1_v && !r_s2_v && !r_s3_v;
  assign commit_busy = r_commit_busy;
  assign w_set       = w_accept ? (NCH'(1) << in_ch) : '0;
  assign w_clr       = r_s3_v ? (NCH'(1) << r_s3_ch) : '0;

  always_comb begin
    w_prod[0] = PW'(r_s1_x)  * PW'(r_active[0]);
    w_prod[1] = PW'(r_s1_x1) * PW'(r_active[1]);
    w_prod[2] = PW'(r_s1_x2) * PW'(r_active[2]);
    w_prod[3] = PW'(r_s1_y1) * PW'(r_active[3]);
    w_prod[4] = PW'(r_s1_y2) * PW'(r_active[4]);
  end

  assign w_sum = AW'(r_s2_p[0]) + AW'(r_s2_p[1]) + AW'(r_s2_p[2])
               - AW'(r_s2_p[3]) - AW'(r_s2_p[4]);
  assign w_rnd = (r_s3_acc + C_HALF) >>> FRAC;

  always_comb begin
    w_sat  = 1'b0;
    w_ysat = w_rnd[DW-1:0];
    if (r_s3_byp) begin
      w_ysat = r_s3_x;
    end else if (w_rnd > C_YMAX) begin
      w_sat  = 1'b1;
      w_ysat = C_YMAX[DW-1:0];
    end else if (w_rnd < C_YMIN) begin
      w_sat  = 1'b1;
      w_ysat = C_YMIN[DW-1:0];
    end
  end

  // The active set only swaps once nothing in S1-S3 can still read it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) begin
        r_shadow[i] <= (i == 0) ? C_UNITY : '0;
        r_active[i] <= (i == 0) ? C_UNITY : '0;
      end
      r_commit_busy <= 1'b0;
    end else begin
      if (coef_we && (coef_addr < 3'd5)) begin
        r_shadow[coef_addr] <= coef_data;
      end
      if (r_commit_busy) begin
        if (w_drained) begin
          for (int i = 0; i < 5; i++) begin
            r_active[i] <= r_shadow[i];
          end
          r_commit_busy <= 1'b0;
        end
      end else if (coef_commit) begin
        r_commit_busy <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_v   <= 1'b0;
      r_s1_byp <= 1'b0;
      r_s1_ch  <= '0;
      r_s1_x   <= '0;
      r_s1_x1  <= '0;
      r_s1_x2  <= '0;
      r_s1_y1  <= '0;
      r_s1_y2  <= '0;
    end else begin
      r_s1_v <= w_accept;
      if (w_accept) begin
        r_s1_byp <= bypass;
        r_s1_ch  <= in_ch;
        r_s1_x   <= x;
        r_s1_x1  <= r_hx1[in_ch];
        r_s1_x2  <= r_hx2[in_ch];
        r_s1_y1  <= r_hy1[in_ch];
        r_s1_y2  <= r_hy2[in_ch];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_v   <= 1'b0;
      r_s2_byp <= 1'b0;
      r_s2_ch  <= '0;
      r_s2_x   <= '0;
      for (int i = 0; i < 5; i++) begin
        r_s2_p[i] <= '0;
      end
    end else begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_byp <= r_s1_byp;
        r_s2_ch  <= r_s1_ch;
        r_s2_x   <= r_s1_x;
        for (int i = 0; i < 5; i++) begin
          r_s2_p[i] <= w_prod[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s3_v   <= 1'b0;
      r_s3_byp <= 1'b0;
      r_s3_ch  <= '0;
      r_s3_x   <= '0;
      r_s3_acc <= '0;
    end else begin
      r_s3_v <= r_s2_v;
      if (r_s2_v) begin
        r_s3_byp <= r_s2_byp;
        r_s3_ch  <= r_s2_ch;
        r_s3_x   <= r_s2_x;
        r_s3_acc <= w_sum;
      end
    end
  end

  // History is written with the saturated result, on the same edge the result is presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      y         <= '0;
      sat_flag  <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        r_hx1[i] <= '0;
        r_hx2[i] <= '0;
        r_hy1[i] <= '0;
        r_hy2[i] <= '0;
      end
    end else begin
      out_valid <= r_s3_v;
      if (r_s3_v) begin
        out_ch           <= r_s3_ch;
        y                <= w_ysat;
        sat_flag         <= w_sat;
        r_hx1[r_s3_ch]   <= r_s3_x;
        r_hx2[r_s3_ch]   <= r_hx1[r_s3_ch];
        r_hy1[r_s3_ch]   <= w_ysat;
        r_hy2[r_s3_ch]   <= r_hy1[r_s3_ch];
      end
    end
  end

endmodule

// File: doc/iir_biquad_mc.md
IIR_BIQUAD_MC -- requirements
Module: iir_biquad_mc

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  DW    32  sample width, signed two's complement
  CW    18  coefficient width, signed
  FRAC  14  coefficient fractional bits
  NCH   4   channel count (>=1)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk          in   1              single clock, rising edge
  reset        in   1              asynchronous, active-high
  in_valid     in   1              sample offered
  in_ready     out  1              sample accepted when in_valid && in_ready
  in_ch        in   clog2(NCH)     channel of offered sample
  x            in   DW             input sample
  out_valid    out  1              one-cycle result strobe
  out_ch       out  clog2(NCH)     channel of result
  y            out  DW             filtered sample
  sat_flag     out  1              result was clipped; valid with out_valid
  bypass       in   1              y = x when high; sampled at acceptance
  coef_we      in   1              write shadow coefficient
  coef_addr    in   3              0=b0 1=b1 2=b2 3=a1 4=a2; 5-7 ignored
  coef_data    in   CW             coefficient value
  coef_commit  in   1              request shadow->active copy
  commit_busy  out  1              commit pending

Function
REQ-003 Per channel: y[n] = sat(round((b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2]) / 2^FRAC)); coefficients are shared, history (x1, x2, y1, y2) is per channel.
REQ-004 The accumulator SHALL be at least DW+CW+3 bits, so no intermediate overflow occurs.
REQ-005 Rounding: add 2^(FRAC-1), then arithmetic right shift by FRAC (round half up).
REQ-006 Saturation: results above 2^(DW-1)-1 or below -2^(DW-1) SHALL clamp to those limits, with sat_flag=1 in the same cycle as out_valid.
REQ-007 Pipeline stages: S1 capture and history fetch; S2 products; S3 sum, round, saturate, history write-back.
REQ-008 A sample accepted at edge t SHALL produce out_valid=1 with its y and out_ch for exactly the cycle following edge t+3.
REQ-009 A busy bit per channel SHALL set on acceptance and clear at the edge where that sample's out_valid rises.
REQ-010 in_ready = !busy[in_ch] && !commit_busy, combinational.
REQ-011 Distinct channels MAY be accepted on consecutive cycles; one channel accepts at most one sample per 3 cycles.
REQ-012 Output order SHALL equal acceptance order.
REQ-013 Bypass: y = x with identical latency, sat_flag=0. History SHALL update with x as the input term and y (=x) as the output term.
REQ-014 coef_we SHALL write the shadow register at coef_addr on the same edge; the active set is unaffected.
REQ-015 coef_commit SHALL set commit_busy on the next edge. While commit_busy=1, in_ready=0.
REQ-016 The active set SHALL be loaded from shadow on the first edge at which no sample is in S1-S3; commit_busy clears on that same edge.
REQ-017 In-flight samples SHALL complete using the old active set.
REQ-018 coef_we and coef_commit in the same cycle: the write lands first, so the commit includes it.
REQ-019 coef_commit while commit_busy=1 SHALL have no further effect.
REQ-020 A channel index >= NCH with in_valid SHALL be held off: in_ready=0 and the sample is never accepted.
REQ-021 History arithmetic wraps nothing: y history stores the saturated y.

Reset
REQ-022 Asserting reset SHALL immediately clear:
  - out_valid, y, out_ch, sat_flag, commit_busy
  - all busy bits and pipeline valids
  - all channel history
REQ-023 Active and shadow coefficients SHALL reset to b0 = 2^FRAC and b1 = b2 = a1 = a2 = 0 (identity filter).
REQ-024 Samples in flight when reset asserts SHALL be discarded and produce no out_valid. in_ready SHALL be 1 on the first cycle after reset deasserts.

Verification
REQ-025 Identity: after reset, ch0 x=1000 accepted at edge t -> out_valid at t+3 with y=1000, out_ch=0, sat_flag=0.
REQ-026 FIR and feedback, one line each:
  - b0=b1=b2=4096, commit, ch1 impulse 16384 then zeros -> y = 4096, 4096, 4096, 0.
  - b0=16384, a1=-8192, impulse 16384 -> y = 16384, 8192, 4096, 2048.
REQ-027 Saturation: b0=32768, x=2147483647 -> y=2147483647, sat_flag=1; x=-2147483648 -> y=-2147483648, sat_flag=1.
REQ-028 Interleave and throttling: ch0..ch3 offered on four consecutive cycles -> outputs in the same order, histories independent; ch0 offered again at t+1 -> in_ready=0 until its result edge.
REQ-029 Commit ordering: coef_commit with 2 samples in flight -> in_ready=0 and commit_busy=1 until drained; those 2 samples use old coefficients, the next sample uses new ones.
REQ-030 Reset mid-operation: reset asserted with 3 samples in flight -> no out_valid appears; a subsequent x=5 returns y=5 (identity, cleared history).
